// File: rtl/intersection_pkg.sv
// Shared intersection definitions: the phase code consumed by led_control and the default dwell times.
package intersection_pkg;

  typedef enum logic [2:0] {
    PH_NS_GREEN  = 3'd0,
    PH_NS_YELLOW = 3'd1,
    PH_ALLRED_A  = 3'd2,
    PH_EW_LEFT   = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5,
    PH_ALLRED_B  = 3'd6,
    PH_NS_LEFT   = 3'd7
  } phase_e;

  localparam int DEF_G_TIME = 10;
  localparam int DEF_Y_TIME = 3;
  localparam int DEF_R_TIME = 2;
  localparam int DEF_L_TIME = 5;
  localparam int DEF_CW     = 5;

endpackage

// File: rtl/dwell_timer.sv
// Per-phase dwell counter: load wins over tick; count and zero are registered, 1-cycle latency.
// Free-running, no backpressure; hold freezes decrement (load still applies).
module dwell_timer #(
  parameter int             CW      = 5,
  parameter logic [CW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  input  logic          hold,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && !hold && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Timed traffic-phase controller with left-turn skipping and emergency all-red preempt.
// All outputs registered, 1-cycle latency from tick/emergency; free-running, no backpressure.
module phase_sequencer
  import intersection_pkg::*;
#(
  parameter int G_TIME = DEF_G_TIME,
  parameter int Y_TIME = DEF_Y_TIME,
  parameter int R_TIME = DEF_R_TIME,
  parameter int L_TIME = DEF_L_TIME,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          ns_left_req,
  input  logic          ew_left_req,
  input  logic          emergency,
  output logic [2:0]    phase,
  output logic [CW-1:0] ticks_left,
  output logic          phase_change,
  output logic          preempt_active
);

  localparam logic [CW-1:0] G_LD = CW'(G_TIME - 1);
  localparam logic [CW-1:0] Y_LD = CW'(Y_TIME - 1);
  localparam logic [CW-1:0] R_LD = CW'(R_TIME - 1);
  localparam logic [CW-1:0] L_LD = CW'(L_TIME - 1);

  phase_e        phase_q, phase_d, emg_tgt, norm_tgt;
  logic          ew_pend_q, ew_pend_d, ns_pend_q, ns_pend_d;
  logic          chg_q, chg_d, preempt_q, preempt_d;
  logic          emg_ok, in_red, hold, load, zero;
  logic [CW-1:0] load_val, count;

  function automatic logic [CW-1:0] dwell_ld(input phase_e p);
    case (p)
      PH_NS_GREEN, PH_EW_GREEN:   return G_LD;
      PH_NS_YELLOW, PH_EW_YELLOW: return Y_LD;
      PH_EW_LEFT, PH_NS_LEFT:     return L_LD;
      default:                    return R_LD;
    endcase
  endfunction

  assign in_red    = (phase_q == PH_ALLRED_A) || (phase_q == PH_ALLRED_B);
  assign hold      = in_red && emergency;
  assign preempt_d = hold;

  always_comb begin
    phase_d  = phase_q;
    load     = 1'b0;
    load_val = R_LD;
    chg_d    = 1'b0;
    emg_ok   = 1'b0;
    emg_tgt  = phase_q;
    norm_tgt = phase_q;

    // Yellow phases are never cut short; all-red phases are handled as a hold.
    case (phase_q)
      PH_NS_GREEN: begin emg_ok = 1'b1; emg_tgt = PH_NS_YELLOW; end
      PH_EW_GREEN: begin emg_ok = 1'b1; emg_tgt = PH_EW_YELLOW; end
      PH_EW_LEFT:  begin emg_ok = 1'b1; emg_tgt = PH_ALLRED_B;  end
      PH_NS_LEFT:  begin emg_ok = 1'b1; emg_tgt = PH_ALLRED_A;  end
      default:     begin emg_ok = 1'b0; emg_tgt = phase_q;      end
    endcase

    case (phase_q)
      PH_NS_GREEN:  norm_tgt = PH_NS_YELLOW;
      PH_NS_YELLOW: norm_tgt = PH_ALLRED_A;
      PH_ALLRED_A:  norm_tgt = (ew_pend_q || ew_left_req) ? PH_EW_LEFT : PH_EW_GREEN;
      PH_EW_LEFT:   norm_tgt = PH_EW_GREEN;
      PH_EW_GREEN:  norm_tgt = PH_EW_YELLOW;
      PH_EW_YELLOW: norm_tgt = PH_ALLRED_B;
      PH_ALLRED_B:  norm_tgt = (ns_pend_q || ns_left_req) ? PH_NS_LEFT : PH_NS_GREEN;
      PH_NS_LEFT:   norm_tgt = PH_NS_GREEN;
    endcase

    // Holding, or the cycle releasing a hold, pins the all-red dwell and swallows tick.
    if (in_red && (emergency || preempt_q)) begin
      load     = 1'b1;
      load_val = R_LD;
    end else if (emg_ok && emergency) begin
      phase_d = emg_tgt;
      chg_d   = 1'b1;
    end else if (tick && zero) begin
      phase_d = norm_tgt;
      chg_d   = 1'b1;
    end

    if (chg_d) begin
      load     = 1'b1;
      load_val = dwell_ld(phase_d);
    end
  end

  assign ew_pend_d = (ew_pend_q || ew_left_req) && !(chg_d && (phase_d == PH_EW_LEFT));
  assign ns_pend_d = (ns_pend_q || ns_left_req) && !(chg_d && (phase_d == PH_NS_LEFT));

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_ALLRED_B;
      ew_pend_q <= 1'b0;
      ns_pend_q <= 1'b0;
      chg_q     <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ew_pend_q <= ew_pend_d;
      ns_pend_q <= ns_pend_d;
      chg_q     <= chg_d;
      preempt_q <= preempt_d;
    end
  end

  dwell_timer #(
    .CW      (CW),
    .RST_VAL (R_LD)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .hold     (hold),
    .count    (count),
    .zero     (zero)
  );

  assign phase          = phase_q;
  assign ticks_left     = count;
  assign phase_change   = chg_q;
  assign preempt_active = preempt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus random traffic against a table-driven model.
module tb_phase_sequencer;

  localparam int G = 10, Y = 3, R = 2, L = 5;

  logic       clk = 1'b0;
  logic       reset, tick, ns_left_req, ew_left_req, emergency;
  logic [2:0] phase;
  logic [4:0] ticks_left;
  logic       phase_change, preempt_active;

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .ns_left_req    (ns_left_req),
    .ew_left_req    (ew_left_req),
    .emergency      (emergency),
    .phase          (phase),
    .ticks_left     (ticks_left),
    .phase_change   (phase_change),
    .preempt_active (preempt_active)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase tables indexed by phase code.
  int dur[8]    = '{G, Y, R, L, G, Y, R, L};
  int nxt[8]    = '{1, 2, 4, 4, 5, 6, 0, 0};
  int emg_to[8] = '{1, -1, -1, 6, 5, -1, -1, 2};
  int m_ph, m_left;
  bit m_ewp, m_nsp, m_pre, m_pc, m_valid = 0;

  task automatic model_step();
    int np;
    bit red;
    if (reset) begin
      m_ph = 6; m_left = R - 1; m_ewp = 0; m_nsp = 0; m_pre = 0; m_pc = 0; m_valid = 1;
      return;
    end
    np  = -1;
    red = (m_ph == 2) || (m_ph == 6);
    if (red && (emergency || m_pre)) m_left = R - 1;
    else if (emergency && emg_to[m_ph] >= 0) np = emg_to[m_ph];
    else if (tick) begin
      if (m_left > 0) m_left--;
      else if (m_ph == 2 && (m_ewp || ew_left_req)) np = 3;
      else if (m_ph == 6 && (m_nsp || ns_left_req)) np = 7;
      else np = nxt[m_ph];
    end
    m_ewp = (m_ewp || ew_left_req) && (np != 3);
    m_nsp = (m_nsp || ns_left_req) && (np != 7);
    m_pre = red && emergency;
    m_pc  = (np >= 0);
    if (np >= 0) begin
      m_ph   = np;
      m_left = dur[np] - 1;
    end
  endtask

  task automatic compare_all();
    if (!m_valid) return;
    check_eq("phase", phase, m_ph);
    check_eq("ticks_left", ticks_left, m_left);
    check_eq("phase_change", phase_change, m_pc);
    check_eq("preempt_active", preempt_active, m_pre);
    check_eq("ew_pend", dut.ew_pend_q, m_ewp);
    check_eq("ns_pend", dut.ns_pend_q, m_nsp);
  endtask

  int cyc = 0;
  int ticks_applied = 0;
  bit ns_on_final = 0;

  // Called at a negedge with inputs set; advances one clock and checks at the next negedge.
  task automatic step();
    tick = (cyc % 8 == 7);
    if (ns_on_final) ns_left_req = tick && (m_ph == 6) && (m_left == 0);
    @(posedge clk);
    model_step();
    cyc++;
    if (tick) ticks_applied++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_phase(input int p, input int budget, input string tag);
    int n = 0;
    while (phase !== 3'(p) && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, phase, p);
  endtask

  initial begin
    int pcs, lefts, n, s, emg_len;
    reset = 1; tick = 0; ns_left_req = 0; ew_left_req = 0; emergency = 0;
    @(negedge clk);
    repeat (3) step();
    check_eq("rst_phase", phase, 6);
    check_eq("rst_ticks_left", ticks_left, R - 1);
    check_eq("rst_phase_change", phase_change, 0);
    check_eq("rst_preempt", preempt_active, 0);
    reset = 0;

    // Basic cycle without left demand: 6->0->1->2->4->5->6.
    pcs = 0; lefts = 0; n = 0;
    while (n < 400) begin
      step();
      n++;
      if (phase_change) pcs++;
      if (phase == 3 || phase == 7) lefts++;
      if (phase_change && phase == 6) break;
    end
    check_eq("basic_transitions", pcs, 6);
    check_eq("basic_no_left", lefts, 0);

    // EW left demand latched during green, served once.
    wait_phase(0, 400, "reach_ns_green");
    ew_left_req = 1; step(); ew_left_req = 0;
    check_eq("ew_pend_latched", dut.ew_pend_q, 1);
    wait_phase(3, 400, "ew_left_served");
    check_eq("ew_pend_cleared", dut.ew_pend_q, 0);
    s = ticks_applied;
    wait_phase(4, 100, "ew_left_to_green");
    check_eq("ew_left_ticks", ticks_applied - s, L);
    wait_phase(2, 800, "reach_allred_a");
    n = 0;
    do begin step(); n++; end while (!phase_change && n < 100);
    check_eq("ew_left_skipped", phase, 4);

    // NS request only on the final tick of phase 6.
    ns_on_final = 1;
    wait_phase(6, 400, "reach_allred_b");
    n = 0;
    do begin step(); n++; end while (!phase_change && n < 100);
    ns_on_final = 0; ns_left_req = 0;
    check_eq("same_cycle_ns_left", phase, 7);

    // Emergency during EW green.
    n = 0;
    while (!(m_ph == 4 && m_left == 6) && n < 1000) begin step(); n++; end
    check_eq("reach_ew_green_6", ticks_left, 6);
    emergency = 1; step();
    check_eq("emg_green_phase", phase, 5);
    check_eq("emg_green_ticks", ticks_left, Y - 1);
    s = ticks_applied;
    wait_phase(6, 100, "emg_yellow_done");
    check_eq("emg_yellow_ticks", ticks_applied - s, Y);
    step();
    check_eq("emg_preempt_rise", preempt_active, 1);
    s = ticks_applied;
    while (ticks_applied - s < 20) step();
    check_eq("emg_hold_phase", phase, 6);
    check_eq("emg_hold_preempt", preempt_active, 1);
    check_eq("emg_hold_ticks", ticks_left, R - 1);
    while (cyc % 8 == 7) step();
    emergency = 0;
    s = ticks_applied;
    wait_phase(0, 100, "emg_release_to_green");
    check_eq("emg_release_ticks", ticks_applied - s, R);

    // Emergency in NS left phase.
    ns_left_req = 1; step(); ns_left_req = 0;
    wait_phase(7, 800, "reach_ns_left");
    emergency = 1; step(); emergency = 0;
    check_eq("emg_ns_left_phase", phase, 2);

    // Reset mid-left-phase with demand pending.
    ew_left_req = 1; step(); ew_left_req = 0;
    n = 0;
    while (!(m_ph == 3 && m_left == 2) && n < 1000) begin step(); n++; end
    check_eq("reach_ew_left_2", phase, 3);
    ns_left_req = 1; ew_left_req = 1; reset = 1; step();
    ns_left_req = 0; ew_left_req = 0; reset = 0;
    check_eq("midrst_phase", phase, 6);
    check_eq("midrst_ticks", ticks_left, R - 1);
    check_eq("midrst_ew_pend", dut.ew_pend_q, 0);
    check_eq("midrst_ns_pend", dut.ns_pend_q, 0);

    // Random traffic.
    emg_len = 0;
    for (int i = 0; i < 4000; i++) begin
      ew_left_req = ($urandom_range(0, 15) == 0);
      ns_left_req = ($urandom_range(0, 15) == 0);
      if (emg_len > 0) begin
        emergency = 1; emg_len--;
      end else begin
        emergency = 0;
        if ($urandom_range(0, 299) == 0) emg_len = $urandom_range(1, 120);
      end
      reset = ($urandom_range(0, 1999) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Timed traffic-phase controller for the intersection. It consumes the 1 Hz tick from the second counter, the left-turn demand sensors and the emergency flag, and produces the 3-bit phase code that drives `led_control`'s `fsmIn`. It sequences green, yellow, all-red and protected-left phases for the two roads. Left-turn phases are skipped when nobody is waiting, and an emergency forces all-red.

## Interface
Parameters:
- `G_TIME`, default 10: green dwell in ticks.
- `Y_TIME`, default 3: yellow dwell in ticks.
- `R_TIME`, default 2: all-red dwell in ticks.
- `L_TIME`, default 5: protected-left dwell in ticks.
- `CW`, default 5: dwell counter width. Every `*_TIME` must be ≥1 and ≤2^CW.

Ports:
- `clk`  in  1: single clock (CLOCK_50 domain).
- `reset`  in  1: synchronous, active-high.
- `tick`  in  1: one-`clk` pulse, once per second.
- `ns_left_req`  in  1: north/south left-turn sensor, level.
- `ew_left_req`  in  1: east/west left-turn sensor, level.
- `emergency`  in  1: preempt request, level.
- `phase`  out  3: phase code for `led_control`.
- `ticks_left`  out  CW: ticks remaining in the current phase, minus 1.
- `phase_change`  out  1: one-cycle pulse in the first cycle of a new phase.
- `preempt_active`  out  1: high while held in all-red by an emergency.

## Operation
Phase codes:
- 0 NS_GREEN
- 1 NS_YELLOW
- 2 ALLRED_A
- 3 EW_LEFT
- 4 EW_GREEN
- 5 EW_YELLOW
- 6 ALLRED_B
- 7 NS_LEFT

Normal transitions occur on a `tick` when `ticks_left==0`:
- 7→0, 0→1, 1→2, 3→4, 4→5, 5→6.
- From 2: go to 3 if `ew_pend`, else 4.
- From 6: go to 7 if `ns_pend`, else 0.

Dwell counter:
- On entry to a phase, load `ticks_left` = that phase's `*_TIME − 1`.
- Each `tick` with `ticks_left>0` decrements it.
- A phase therefore lasts exactly `*_TIME` ticks.

Demand latches:
- `ew_pend` is set by `ew_left_req` in any cycle and cleared on entry to 3.
- `ns_pend` is set by `ns_left_req` in any cycle and cleared on entry to 7.
- A skip decision uses `pend | req` from the same cycle, so a request arriving on the decision cycle is served.
- Set and clear in the same cycle: clear wins.

Emergency preempt is evaluated every cycle, independent of `tick`:
- In 0: go to 1 immediately with a full `Y_TIME` load.
- In 4: go to 5 immediately with a full `Y_TIME` load.
- In 3: go to 6 immediately.
- In 7: go to 2 immediately.
- In 1 or 5: finish the yellow normally.
- In 2 or 6 while `emergency` is high: hold the phase, hold `ticks_left` at `R_TIME−1`, set `preempt_active=1`, and ignore `tick`.
- When `emergency` deasserts in a hold: reload `R_TIME−1` and clear `preempt_active`. Normal sequencing then resumes, with the skip decision as above.

## Timing
- Reset values: `phase=6`, `ticks_left=R_TIME−1`, `ew_pend=ns_pend=0`, `phase_change=0`, `preempt_active=0`.
- All outputs are registered.
- `phase` changes in the cycle after the qualifying `tick` or `emergency` sample.
- `phase_change` is high for exactly that first cycle of the new phase.
- `preempt_active` rises in the cycle after the first cycle in which the sequencer is in 2 or 6 with `emergency` high.
- Priority order: `reset` > emergency transition > tick transition > decrement.
- `tick` coincident with an emergency transition is consumed by the emergency transition; it does not also decrement.
- Reset asserted mid-phase or mid-preempt returns to the reset values on the next edge, with no partial state retained.
- `tick` asserted for more than one cycle is treated as multiple ticks. Upstream guarantees single-cycle pulses.
- Counter arithmetic is unsigned `CW`-bit. `ticks_left` never wraps because a decrement is suppressed at 0.

## Structure
- Shared package `intersection_pkg`:
  - phase code constants `PH_NS_GREEN` … `PH_NS_LEFT` (3-bit), which `led_control` also uses;
  - default dwell constants.
- Sub-module `dwell_timer`, containing the load/decrement/zero-detect logic for `ticks_left`:
  - inputs: `clk`, `reset`, `load`, `load_val`, `tick`, `hold`;
  - outputs: `count`, `zero`.
- The sequencer FSM, demand latches and preempt logic stay in `phase_sequencer`.

## Test plan
The first four scenarios use the default parameters. `tick` is one pulse every 8 `clk` cycles.

- **Reset and basic cycle, no left requests:**
  - After reset, `phase` sequence is 6(2 ticks)→0(10)→1(3)→2(2)→4(10)→5(3)→6.
  - Phase 3 and phase 7 never appear.
  - `phase_change` pulses once per transition.
- **Left demand:**
  - Stimulus: a one-cycle `ew_left_req` during phase 0.
  - Required: 2→3 for 5 ticks→4, and `ew_pend` clears on entry to 3.
  - Next cycle with no request: 2→4.
- **Same-cycle request:**
  - Stimulus: `ns_left_req` asserted only on the cycle of the final `tick` of phase 6.
  - Required: next `phase=7`.
- **Emergency during green:**
  - Stimulus: `emergency` high with `phase=4`, `ticks_left=6`.
  - Required: next cycle `phase=5`, `ticks_left=2`. Then after 3 ticks `phase=6` with `preempt_active=1`, held for 20 ticks.
  - Stimulus: drop `emergency`.
  - Required: 2 ticks later `phase=0`.
- **Emergency during left phase:**
  - Stimulus: `emergency` asserted in phase 7.
  - Required: next cycle `phase=2`.
- **Mid-operation reset:**
  - Stimulus: `reset` asserted in phase 3 with `ticks_left=2`.
  - Required: next edge `phase=6`, `ticks_left=1`, all pending latches 0.
